// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - serial ADC controller, MSB-first deserializer and one-entry sample buffer
// Define ADC_DIFF_CHECK_EN to flag adc_dout_n != ~adc_dout_p captures on diff_err.
module adc_serial_rx #(
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 4,
  parameter int WAKE_CYC = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CNT_W-1:0]  cmd_num,
  output logic              cmd_ready,
  output logic              adc_pwdn_n,
  output logic              adc_clk,
  output logic              adc_start,
  input  logic              adc_dout_p,
  input  logic              adc_dout_n,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_last,
  output logic              busy,
  output logic              overflow,
  output logic              diff_err
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAKE_W = $clog2(WAKE_CYC + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAKE, S_START, S_SHIFT, S_STORE} state_t;
  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [DATA_W-1:0] shreg;
  logic              accept, toggle, rise_tick, fall_tick, capture, push, pop;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready && (cmd_num != '0);
  assign toggle    = (state_q != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = toggle && !adc_clk;
  assign fall_tick = toggle && adc_clk;
  assign capture   = (state_q == S_SHIFT) && fall_tick;
  assign push      = (state_q == S_STORE);
  assign pop       = smp_valid && smp_ready;

  // START raises adc_start on its first rise_tick and leaves on the next one
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAKE;
      S_WAKE:  if (rise_tick && (wake_cnt == WAKE_W'(WAKE_CYC - 1))) state_d = S_START;
      S_START: if (rise_tick && adc_start) state_d = S_SHIFT;
      S_SHIFT: if (fall_tick && (bit_cnt == BIT_W'(DATA_W - 1))) state_d = S_STORE;
      S_STORE: state_d = (burst_cnt == CNT_W'(1)) ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt    <= '0;
      adc_clk    <= 1'b0;
      adc_pwdn_n <= 1'b0;
      adc_start  <= 1'b0;
      wake_cnt   <= '0;
      bit_cnt    <= '0;
      burst_cnt  <= '0;
      shreg      <= '0;
    end else begin
      state_q    <= state_d;
      adc_pwdn_n <= (state_d != S_IDLE);

      // divider parked at zero with adc_clk low whenever idle or returning to idle
      if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
        div_cnt <= '0;
        adc_clk <= 1'b0;
      end else if (toggle) begin
        div_cnt <= '0;
        adc_clk <= ~adc_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state_q != S_WAKE) wake_cnt <= '0;
      else if (rise_tick)    wake_cnt <= wake_cnt + 1'b1;

      if (state_d == S_IDLE)                       adc_start <= 1'b0;
      else if ((state_q == S_START) && rise_tick)  adc_start <= ~adc_start;

      if (state_q != S_SHIFT) bit_cnt <= '0;
      else if (fall_tick)     bit_cnt <= bit_cnt + 1'b1;

      if (capture) shreg <= {shreg[DATA_W-2:0], adc_dout_p};

      if (accept)    burst_cnt <= cmd_num;
      else if (push) burst_cnt <= burst_cnt - 1'b1;
    end
  end

  // a push into a full buffer only succeeds if the consumer pops the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_valid <= 1'b0;
      smp_data  <= '0;
      smp_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) overflow <= 1'b0;
      if (push && (!smp_valid || pop)) begin
        smp_valid <= 1'b1;
        smp_data  <= shreg;
        smp_last  <= (burst_cnt == CNT_W'(1));
      end else begin
        if (push) overflow  <= 1'b1;
        if (pop)  smp_valid <= 1'b0;
      end
    end
  end

`ifdef ADC_DIFF_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                         diff_err <= 1'b0;
    else if (accept)                                 diff_err <= 1'b0;
    else if (capture && (adc_dout_n == adc_dout_p))  diff_err <= 1'b1;
  end
`else
  logic unused_dout_n;
  assign unused_dout_n = adc_dout_n;
  assign diff_err      = 1'b0;
`endif

endmodule
